// File: rtl/seq_divider_16_bit.sv
// Multi-cycle restoring unsigned divider: one quotient bit per clock, WIDTH
// iterations per division, with divide-by-zero short-circuited straight to DONE.
module seq_divider_16_bit #(
    parameter int WIDTH    = 16,
    parameter int CNT_BITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Partial remainder stays below the divisor, so its top bit is always
    // zero between iterations and is not stored; the shifted value is WIDTH+1.
    logic [WIDTH-1:0]    r;
    logic [WIDTH-1:0]    q;
    logic [WIDTH-1:0]    dsr;
    logic [CNT_BITS-1:0] cnt;

    logic [WIDTH:0]      r_shift;
    logic [WIDTH:0]      trial;
    logic                fits;
    logic [WIDTH-1:0]    r_next;
    logic [WIDTH-1:0]    q_next;
    logic                last_iter;
    logic                accept;
    logic                zero_div;

    assign r_shift   = {r, q[WIDTH-1]};
    assign trial     = r_shift - {1'b0, dsr};
    assign fits      = ~trial[WIDTH];
    assign r_next    = fits ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign q_next    = {q[WIDTH-2:0], fits};
    assign last_iter = (cnt == CNT_BITS'(WIDTH - 1));
    assign accept    = (state == IDLE) && start;
    assign zero_div  = (divisor == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = zero_div ? DONE : CALC;
            CALC: if (last_iter) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r   <= '0;
            q   <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (accept && !zero_div) begin
            r   <= '0;
            q   <= dividend;
            dsr <= divisor;
            cnt <= '0;
        end else if (state == CALC) begin
            r   <= r_next;
            q   <= q_next;
            cnt <= cnt + 1'b1;
        end
    end

    // Results only move on the edge entering DONE, never mid-calculation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && zero_div) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (state == CALC && last_iter) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider_16_bit.sv
// Directed and randomised checks of seq_divider_16_bit against a plain
// arithmetic model (a/b, a%b, all-ones quotient on divide-by-zero).
module tb_seq_divider_16_bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider_16_bit #(.WIDTH(16), .CNT_BITS(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; inputs change at negedge so the posedge sees them settled.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    endtask

    // Called at the first negedge after the accepting edge. Waits (bounded) for
    // done, checks latency, busy, result hold, results and a single-cycle pulse.
    task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input bit noise, input bit full);
        int lat;
        int busy_cyc;
        bit held;
        logic [15:0] q0, r0, eq, er;
        logic        z0;
        q0 = quotient; r0 = remainder; z0 = div_by_zero;
        eq = (b == 0) ? 16'hFFFF : a / b;
        er = (b == 0) ? a : a % b;
        lat = 0; busy_cyc = 0; held = 1'b1;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) held = 1'b0;
            if (noise && (lat == 2 || lat == 9)) begin
                start = 1'b1; dividend = 16'd9; divisor = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (busy) busy_cyc++;
        chk({tag, ":done_seen"}, {31'd0, done}, 32'd1);
        if (full) begin
            chk({tag, ":latency"}, lat, (b == 0) ? 32'd0 : 32'd16);
            chk({tag, ":busy_cycles"}, busy_cyc, (b == 0) ? 32'd1 : 32'd17);
            chk({tag, ":held"}, {31'd0, held}, 32'd1);
        end
        chk({tag, ":quotient"}, quotient, eq);
        chk({tag, ":remainder"}, remainder, er);
        chk({tag, ":dbz"}, {31'd0, div_by_zero}, {31'd0, b == 0});
        if (b != 0 && full) begin
            chk({tag, ":identity"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk({tag, ":rem_lt_div"}, {31'd0, remainder < b}, 32'd1);
        end
        @(negedge clk);
        chk({tag, ":done_width"}, {31'd0, done}, 32'd0);
        if (full) chk({tag, ":idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int extra_done;
        logic [15:0] a, b;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("reset:quotient", quotient, 32'd0);
        chk("reset:remainder", remainder, 32'd0);
        chk("reset:flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        rst = 1'b0;

        // 1: basic division
        start_op(16'd1000, 16'd7);
        run_check("t1", 16'd1000, 16'd7, 1'b0, 1'b1);

        // 2: all-ones / 1, then small/large with hold of previous result
        start_op(16'hFFFF, 16'd1);
        run_check("t2a", 16'hFFFF, 16'd1, 1'b0, 1'b1);
        start_op(16'd3, 16'd10);
        run_check("t2b", 16'd3, 16'd10, 1'b0, 1'b1);

        // 3: divide by zero, then flag cleared by a normal division
        start_op(16'd5, 16'd0);
        run_check("t3a", 16'd5, 16'd0, 1'b0, 1'b1);
        start_op(16'd20, 16'd4);
        run_check("t3b", 16'd20, 16'd4, 1'b0, 1'b1);

        // 4: start pulses during CALC are ignored, exactly one done
        start_op(16'd1000, 16'd7);
        run_check("t4", 16'd1000, 16'd7, 1'b1, 1'b1);
        extra_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        chk("t4:no_extra_done", extra_done, 32'd0);

        // 5: reset mid-calculation discards the operation
        start_op(16'd60000, 16'd123);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5:rst_quotient", quotient, 32'd0);
        chk("t5:rst_remainder", remainder, 32'd0);
        chk("t5:rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        chk("t5:no_done_after_rst", extra_done, 32'd0);
        start_op(16'd60000, 16'd123);
        run_check("t5b", 16'd60000, 16'd123, 1'b0, 1'b1);

        // 6: randomised operands with corner divisors mixed in
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = 16'd0;
                1: b = 16'd1;
                2: b = 16'hFFFF;
                3: b = a + 16'($urandom_range(1, 200));
                default: b = 16'($urandom);
            endcase
            start_op(a, b);
            run_check("rand", a, b, 1'b0, (i % 16) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
